// File: rtl/complete_arbiter_if.sv
// Completion arbiter bus: requester-side result handshake plus the registered
// completion ports that feed the ROB and the wakeup bus.
interface complete_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 4
) ();
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ*32-1:0]       req_pc;
  logic [NUM_REQ*PREG_W-1:0]   req_preg;
  logic [NUM_REQ*ROB_W-1:0]    req_rob;
  logic [NUM_REQ-1:0]          req_is_store;
  logic [NUM_REQ-1:0]          req_ready;

  logic [NUM_PORTS-1:0]        cmp_valid;
  logic [NUM_PORTS*DATA_W-1:0] cmp_data;
  logic [NUM_PORTS*32-1:0]     cmp_pc;
  logic [NUM_PORTS*PREG_W-1:0] cmp_preg;
  logic [NUM_PORTS*ROB_W-1:0]  cmp_rob;
  logic [NUM_PORTS-1:0]        cmp_is_store;
  logic [NUM_PORTS*SRC_W-1:0]  cmp_src;

  modport master (
    output req_valid, req_data, req_pc, req_preg, req_rob, req_is_store,
    input  req_ready,
    input  cmp_valid, cmp_data, cmp_pc, cmp_preg, cmp_rob, cmp_is_store, cmp_src
  );

  modport slave (
    input  req_valid, req_data, req_pc, req_preg, req_rob, req_is_store,
    output req_ready,
    output cmp_valid, cmp_data, cmp_pc, cmp_preg, cmp_rob, cmp_is_store, cmp_src
  );
endinterface

// File: rtl/complete_arbiter.sv
// Complete-stage arbiter: per-FU skid FIFOs drained round-robin onto up to
// NUM_PORTS registered ROB completion / wakeup ports.
module complete_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 4,
  parameter int DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cmp_hold,
  complete_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic [PREG_W-1:0] preg;
    logic [ROB_W-1:0]  rob;
    logic              is_store;
  } entry_t;

  entry_t             mem_r      [NUM_REQ][DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r   [NUM_REQ];
  logic [PTR_W-1:0]   rd_ptr_r   [NUM_REQ];
  logic [CNT_W-1:0]   count_r    [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr_r;

  logic [NUM_REQ-1:0] ready_s;
  logic [NUM_REQ-1:0] push_s;
  logic [NUM_REQ-1:0] pop_s;
  logic [NUM_REQ-1:0] grant_s;
  entry_t             in_entry_s [NUM_REQ];
  logic [NUM_PORTS-1:0] port_vld_s;
  logic [SRC_W-1:0]   port_src_s  [NUM_PORTS];
  entry_t             port_head_s [NUM_PORTS];
  logic [SRC_W-1:0]   rr_next_s;
  logic               advance_s;

  logic [NUM_PORTS-1:0] cmp_valid_r;
  entry_t             cmp_entry_r [NUM_PORTS];
  logic [SRC_W-1:0]   cmp_src_r   [NUM_PORTS];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Ready depends on registered count only: no combinational grant-to-ready path.
  always_comb begin
    advance_s = ~cmp_hold & ~flush;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i]    = (count_r[i] < CNT_W'(DEPTH));
      push_s[i]     = bus.req_valid[i] & ready_s[i] & ~flush;
      pop_s[i]      = grant_s[i] & advance_s;
      in_entry_s[i] = '{data:     bus.req_data[i*DATA_W +: DATA_W],
                        pc:       bus.req_pc[i*32 +: 32],
                        preg:     bus.req_preg[i*PREG_W +: PREG_W],
                        rob:      bus.req_rob[i*ROB_W +: ROB_W],
                        is_store: bus.req_is_store[i]};
    end
  end

  // Round-robin scan from rr_ptr: the n-th non-empty FIFO found takes port n.
  always_comb begin
    logic [SRC_W-1:0] idx;
    int found;
    grant_s    = '0;
    port_vld_s = '0;
    rr_next_s  = rr_ptr_r;
    found      = 0;
    idx        = SRC_W'(0);
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_src_s[p]  = SRC_W'(0);
      port_head_s[p] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = SRC_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      if ((count_r[idx] != CNT_W'(0)) && (found < NUM_PORTS)) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (p == found) begin
            port_vld_s[p]  = 1'b1;
            port_src_s[p]  = idx;
            port_head_s[p] = mem_r[idx][rd_ptr_r[idx]];
          end else begin
          end
        end
        grant_s[idx] = 1'b1;
        rr_next_s    = SRC_W'((int'(idx) + 1) % NUM_REQ);
        found        = found + 1;
      end else begin
      end
    end
  end

  // FIFO pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_r[i] <= PTR_W'(0);
        rd_ptr_r[i] <= PTR_W'(0);
        count_r[i]  <= CNT_W'(0);
      end
      rr_ptr_r <= SRC_W'(0);
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_r[i] <= PTR_W'(0);
        rd_ptr_r[i] <= PTR_W'(0);
        count_r[i]  <= CNT_W'(0);
      end
      rr_ptr_r <= SRC_W'(0);
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= ptr_inc(wr_ptr_r[i]);
        if (pop_s[i])  rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
      if (advance_s && (|grant_s)) rr_ptr_r <= rr_next_s;
    end
  end

  // FIFO storage; contents are meaningless while the matching count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_s[i]) mem_r[i][wr_ptr_r[i]] <= in_entry_s[i];
    end
  end

  // Completion port registers; ungranted ports drop valid but keep payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_r <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cmp_entry_r[p] <= '0;
        cmp_src_r[p]   <= SRC_W'(0);
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_vld_s[p] && advance_s) begin
          cmp_valid_r[p] <= 1'b1;
          cmp_entry_r[p] <= port_head_s[p];
          cmp_src_r[p]   <= port_src_s[p];
        end else begin
          cmp_valid_r[p] <= 1'b0;
        end
      end
    end
  end

  // Flatten port registers onto the bus.
  always_comb begin
    bus.req_ready    = ready_s;
    bus.cmp_valid    = cmp_valid_r;
    bus.cmp_data     = '0;
    bus.cmp_pc       = '0;
    bus.cmp_preg     = '0;
    bus.cmp_rob      = '0;
    bus.cmp_is_store = '0;
    bus.cmp_src      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.cmp_data[p*DATA_W +: DATA_W] = cmp_entry_r[p].data;
      bus.cmp_pc[p*32 +: 32]           = cmp_entry_r[p].pc;
      bus.cmp_preg[p*PREG_W +: PREG_W] = cmp_entry_r[p].preg;
      bus.cmp_rob[p*ROB_W +: ROB_W]    = cmp_entry_r[p].rob;
      bus.cmp_is_store[p]              = cmp_entry_r[p].is_store;
      bus.cmp_src[p*SRC_W +: SRC_W]    = cmp_src_r[p];
    end
  end
endmodule

// File: tb/tb_complete_arbiter.sv
// Directed self-checking bench for complete_arbiter (4 requesters, 2 ports).
module tb_complete_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic cmp_hold = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  complete_arbiter_if bus ();

  complete_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .cmp_hold (cmp_hold),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req_valid    = 4'b0000;
    bus.req_data     = '0;
    bus.req_pc       = '0;
    bus.req_preg     = '0;
    bus.req_rob      = '0;
    bus.req_is_store = 4'b0000;
  endtask

  task automatic set_req(input int i, input logic [31:0] data, input logic [5:0] preg,
                         input logic [3:0] rob, input logic st);
    bus.req_valid[i]          = 1'b1;
    bus.req_data[i*32 +: 32]  = data;
    bus.req_pc[i*32 +: 32]    = 32'h0000_1000 + 32'(i);
    bus.req_preg[i*6 +: 6]    = preg;
    bus.req_rob[i*4 +: 4]     = rob;
    bus.req_is_store[i]       = st;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; cmp_hold = 1'b0;
    clear_req();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_req();
    tick(); tick();
    rst = 1'b0;
    tick();
    n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", bus.cmp_valid); else n_pass++;
    n_total++; if (bus.req_ready !== 4'b1111) $display("FAIL reset_ready: got %b want 1111", bus.req_ready); else n_pass++;
    n_total++; if (bus.cmp_data !== 64'h0) $display("FAIL reset_data: got %h want 0", bus.cmp_data); else n_pass++;
    n_total++; if ({bus.cmp_pc, bus.cmp_preg, bus.cmp_rob, bus.cmp_is_store, bus.cmp_src} !== 96'h0)
      $display("FAIL reset_fields: got %h want 0", {bus.cmp_pc, bus.cmp_preg, bus.cmp_rob, bus.cmp_is_store, bus.cmp_src}); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 32'hDEAD_BEEF, 6'd5, 4'd3, 1'b0);
    tick();
    clear_req();
    n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL single_no_bypass: got %b want 00", bus.cmp_valid); else n_pass++;
    tick();
    n_total++; if (bus.cmp_valid !== 2'b01) $display("FAIL single_valid: got %b want 01", bus.cmp_valid); else n_pass++;
    n_total++; if (bus.cmp_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h want deadbeef", bus.cmp_data[31:0]); else n_pass++;
    n_total++; if (bus.cmp_preg[5:0] !== 6'd5) $display("FAIL single_preg: got %0d want 5", bus.cmp_preg[5:0]); else n_pass++;
    n_total++; if (bus.cmp_rob[3:0] !== 4'd3) $display("FAIL single_rob: got %0d want 3", bus.cmp_rob[3:0]); else n_pass++;
    n_total++; if (bus.cmp_src[1:0] !== 2'd0) $display("FAIL single_src: got %0d want 0", bus.cmp_src[1:0]); else n_pass++;
    n_total++; if (bus.cmp_pc[31:0] !== 32'h0000_1000) $display("FAIL single_pc: got %h want 00001000", bus.cmp_pc[31:0]); else n_pass++;
    tick();
    n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL single_drain: got %b want 00", bus.cmp_valid); else n_pass++;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h10 + 32'(i), 6'(i + 8), 4'(i), 1'b0);
    bus.req_is_store[3] = 1'b1;
    tick();
    clear_req();
    tick();
    n_total++; if (bus.cmp_valid !== 2'b11) $display("FAIL rr_first_valid: got %b want 11", bus.cmp_valid); else n_pass++;
    n_total++; if (bus.cmp_src !== 4'b0100) $display("FAIL rr_first_src: got %b want 0100", bus.cmp_src); else n_pass++;
    n_total++; if (bus.cmp_data !== {32'h11, 32'h10}) $display("FAIL rr_first_data: got %h want 0000001100000010", bus.cmp_data); else n_pass++;
    tick();
    n_total++; if (bus.cmp_valid !== 2'b11) $display("FAIL rr_second_valid: got %b want 11", bus.cmp_valid); else n_pass++;
    n_total++; if (bus.cmp_src !== 4'b1110) $display("FAIL rr_second_src: got %b want 1110", bus.cmp_src); else n_pass++;
    n_total++; if (bus.cmp_data !== {32'h13, 32'h12}) $display("FAIL rr_second_data: got %h want 0000001300000012", bus.cmp_data); else n_pass++;
    n_total++; if (bus.cmp_is_store !== 2'b10) $display("FAIL rr_second_store: got %b want 10", bus.cmp_is_store); else n_pass++;
    tick();
    n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL rr_idle_valid: got %b want 00", bus.cmp_valid); else n_pass++;
    // rr_ptr is back at 0, so requesters 3 and 1 must land as port0=1, port1=3
    set_req(1, 32'h21, 6'd1, 4'd1, 1'b0);
    set_req(3, 32'h23, 6'd3, 4'd3, 1'b0);
    tick();
    clear_req();
    tick();
    n_total++; if (bus.cmp_src !== 4'b1101) $display("FAIL rr_ptr_wrap: got %b want 1101", bus.cmp_src); else n_pass++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    cmp_hold = 1'b1;
    set_req(3, 32'hA1, 6'd11, 4'd1, 1'b1);
    n_total++; if (bus.req_ready[3] !== 1'b1) $display("FAIL bp_ready0: got %b want 1", bus.req_ready[3]); else n_pass++;
    tick();
    set_req(3, 32'hA2, 6'd12, 4'd2, 1'b1);
    n_total++; if (bus.req_ready[3] !== 1'b1) $display("FAIL bp_ready1: got %b want 1", bus.req_ready[3]); else n_pass++;
    tick();
    set_req(3, 32'hA3, 6'd13, 4'd3, 1'b1);
    n_total++; if (bus.req_ready !== 4'b0111) $display("FAIL bp_full: got %b want 0111", bus.req_ready); else n_pass++;
    tick();
    n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL bp_held: got %b want 00", bus.cmp_valid); else n_pass++;
    clear_req();
    cmp_hold = 1'b0;
    tick();
    n_total++; if ({bus.cmp_valid, bus.cmp_src[1:0], bus.cmp_data[31:0]} !== {2'b01, 2'd3, 32'hA1})
      $display("FAIL bp_first: got %h want 1_3_000000a1", {bus.cmp_valid, bus.cmp_src[1:0], bus.cmp_data[31:0]}); else n_pass++;
    n_total++; if (bus.req_ready[3] !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", bus.req_ready[3]); else n_pass++;
    tick();
    n_total++; if ({bus.cmp_valid, bus.cmp_data[31:0]} !== {2'b01, 32'hA2})
      $display("FAIL bp_second: got %h want 1_000000a2", {bus.cmp_valid, bus.cmp_data[31:0]}); else n_pass++;
    tick();
    n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL bp_third_dropped: got %b want 00", bus.cmp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 32'hB0 + 32'(k), 6'd7, 4'(k), 1'b0);
      tick();
      if (k > 0) begin
        n_total++; if ({bus.cmp_valid, bus.cmp_data[31:0]} !== {2'b01, 32'hB0 + 32'(k - 1)})
          $display("FAIL b2b_out%0d: got %h want 1_%h", k, {bus.cmp_valid, bus.cmp_data[31:0]}, 32'hB0 + 32'(k - 1)); else n_pass++;
        n_total++; if (bus.req_ready[0] !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", k, bus.req_ready[0]); else n_pass++;
      end
    end
    clear_req();
    tick();
    n_total++; if ({bus.cmp_valid, bus.cmp_data[31:0]} !== {2'b01, 32'hB3})
      $display("FAIL b2b_last: got %h want 1_000000b3", {bus.cmp_valid, bus.cmp_data[31:0]}); else n_pass++;
    tick();
    n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL b2b_empty: got %b want 00", bus.cmp_valid); else n_pass++;
  endtask

  task automatic test_hold_flush();
    do_reset();
    cmp_hold = 1'b1;
    set_req(1, 32'hC1, 6'd1, 4'd1, 1'b0);
    set_req(2, 32'hC2, 6'd2, 4'd2, 1'b0);
    tick();
    clear_req();
    tick();
    n_total++; if ({bus.cmp_valid, bus.req_ready} !== {2'b00, 4'b1111})
      $display("FAIL hold_1: got %b want 001111", {bus.cmp_valid, bus.req_ready}); else n_pass++;
    set_req(1, 32'hD1, 6'd1, 4'd1, 1'b0);
    set_req(2, 32'hD2, 6'd2, 4'd2, 1'b0);
    tick();
    clear_req();
    n_total++; if ({bus.cmp_valid, bus.req_ready} !== {2'b00, 4'b1001})
      $display("FAIL hold_2: got %b want 001001", {bus.cmp_valid, bus.req_ready}); else n_pass++;
    tick();
    n_total++; if ({bus.cmp_valid, bus.req_ready} !== {2'b00, 4'b1001})
      $display("FAIL hold_3: got %b want 001001", {bus.cmp_valid, bus.req_ready}); else n_pass++;
    flush = 1'b1;
    set_req(2, 32'hE2, 6'd2, 4'd2, 1'b0);
    tick();
    flush = 1'b0; cmp_hold = 1'b0;
    clear_req();
    n_total++; if ({bus.cmp_valid, bus.req_ready} !== {2'b00, 4'b1111})
      $display("FAIL flush_clear: got %b want 001111", {bus.cmp_valid, bus.req_ready}); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL flush_quiet%0d: got %b want 00", k, bus.cmp_valid); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(0, 32'hF0, 6'd1, 4'd1, 1'b0);
    set_req(1, 32'hF1, 6'd2, 4'd2, 1'b0);
    tick();
    set_req(0, 32'h60, 6'd3, 4'd3, 1'b0);
    set_req(1, 32'h61, 6'd4, 4'd4, 1'b0);
    set_req(2, 32'h62, 6'd5, 4'd5, 1'b0);
    tick();
    clear_req();
    n_total++; if ({bus.cmp_valid, bus.cmp_data} !== {2'b11, 32'hF1, 32'hF0})
      $display("FAIL arst_pre: got %h want 3_000000f1000000f0", {bus.cmp_valid, bus.cmp_data}); else n_pass++;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_total++; if ({bus.cmp_valid, bus.cmp_data} !== 66'h0) $display("FAIL arst_clear: got %h want 0", {bus.cmp_valid, bus.cmp_data}); else n_pass++;
    n_total++; if (bus.req_ready !== 4'b1111) $display("FAIL arst_ready: got %b want 1111", bus.req_ready); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (bus.cmp_valid !== 2'b00) $display("FAIL arst_stale%0d: got %b want 00", k, bus.cmp_valid); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_pressure();
    test_back_to_back();
    test_hold_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
